// File: rtl/dozen_ctrl.sv
// dozen_ctrl: groups item strobes into boxes and sequences bounded counting runs (IDLE/RUN/PAUSE/DONE).
// Latency: every output is registered; a command or item sampled at edge N shows on the outputs after edge N.
// Backpressure: none; items outside RUN, or in a pause cycle, are dropped. Optional macro: AUTO_RESTART_EN.
module dozen_ctrl #(
  parameter int unsigned ITEMS_PER_BOX = 12,
  parameter int unsigned MAX_BOXES     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       item,
  input  logic [3:0] target,
  output logic [3:0] item_cnt,
  output logic [3:0] box_cnt,
  output logic       box_pulse,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ITEM = 4'(ITEMS_PER_BOX - 1);
  localparam logic [3:0] MAX_TGT   = 4'(MAX_BOXES);

  state_t     st;
  logic [3:0] tgt;
  logic       start_ok;
  logic       box_close;
  logic [3:0] box_nxt;

  // A start is only honoured with a target in 1..MAX_BOXES.
  assign start_ok  = start && (target != 4'd0) && (target <= MAX_TGT);
  // An item closes the box when it is the last one; pause in the same cycle drops it.
  assign box_close = item && !pause && (item_cnt == LAST_ITEM);
  assign box_nxt   = box_cnt + 4'd1;
  assign state     = st;

  // Run state machine with counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= S_IDLE;
      tgt       <= 4'd0;
      item_cnt  <= 4'd0;
      box_cnt   <= 4'd0;
      box_pulse <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      box_pulse <= 1'b0;
`ifdef AUTO_RESTART_EN
      done      <= 1'b0;
`endif
      if (stop) begin
        st       <= S_IDLE;
        item_cnt <= 4'd0;
        box_cnt  <= 4'd0;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else begin
        case (st)
          S_IDLE, S_DONE: begin
            // Start from IDLE or from a finished run: fresh counters, new target.
            if (start_ok) begin
              st       <= S_RUN;
              tgt      <= target;
              item_cnt <= 4'd0;
              box_cnt  <= 4'd0;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
          S_RUN: begin
            if (pause) begin
              st <= S_PAUSE;
            end else if (box_close) begin
              item_cnt  <= 4'd0;
              box_pulse <= 1'b1;
              if (box_nxt == tgt) begin
`ifdef AUTO_RESTART_EN
                // Final box: keep running with the same target, flag a one-cycle done.
                box_cnt <= 4'd0;
                done    <= 1'b1;
`else
                box_cnt <= box_nxt;
                st      <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
`endif
              end else begin
                box_cnt <= box_nxt;
              end
            end else if (item) begin
              item_cnt <= item_cnt + 4'd1;
            end
          end
          S_PAUSE: begin
            if (!pause) st <= S_RUN;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dozen_ctrl.md
# dozen_ctrl

Run controller for the dozen-counting datapath. It accepts item strobes and groups them into boxes of ITEMS_PER_BOX items, counting boxes up to a target. It sequences each run through a start/pause/stop/done state machine. It sits between the item-sensor front end and the display/status logic, replacing free-running counting with commanded, bounded runs.

## Interface
- ITEMS_PER_BOX, 12, items per box; legal range 2..15
- MAX_BOXES, 9, largest accepted target; legal range 1..15
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets at the next clk rising edge)
- start  in  1  run command, one-cycle strobe
- stop  in  1  abort command, one-cycle strobe
- pause  in  1  level; holds a run while high
- item  in  1  one-cycle strobe per item
- target  in  4  boxes per run; sampled only when start is accepted
- item_cnt  out  4  items in current box, 0..ITEMS_PER_BOX-1
- box_cnt  out  4  boxes completed in current run
- box_pulse  out  1  high for one cycle after a box closes
- busy  out  1  high in RUN or PAUSE
- done  out  1  run complete (see Configuration)
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Reset values: state=IDLE, item_cnt=0, box_cnt=0, box_pulse=0, busy=0, done=0, target register=0.
- The following command priority applies per cycle: rst > stop > start > pause > item.
- IDLE:
  - start with 1 <= target <= MAX_BOXES: latch target, clear both counters, go to RUN.
  - start with target=0 or target>MAX_BOXES: ignored; stay in IDLE.
- RUN:
  - item=1 increments item_cnt.
  - If item_cnt==ITEMS_PER_BOX-1 when item=1: item_cnt becomes 0, box_cnt increments, box_pulse=1 on the next cycle.
  - If that increment makes box_cnt equal the latched target, go to DONE on the same edge.
  - pause=1 (and no stop) goes to PAUSE. An item strobed in the same cycle is dropped.
  - start is ignored.
- PAUSE:
  - Counters hold; items are ignored.
  - pause=0 returns to RUN.
  - start is ignored.
- DONE:
  - Counters hold final values: box_cnt=target, item_cnt=0. done=1.
  - start (valid target) clears counters, latches the new target, and goes to RUN.
  - Items are ignored.
- stop, from any state: go to IDLE, clear both counters.
- Counters never wrap past their limits. box_cnt is bounded by the target, which is at most 15.
- Changing target outside an accepted start has no effect.

## Timing
- All outputs are registered, with zero combinational input-to-output paths.
- An item accepted at edge N is visible in item_cnt after edge N.
- box_pulse is high for exactly the one cycle after the closing edge, coincident with the updated box_cnt.
- The closing edge of the final box sets state=DONE, done=1, and busy=0 all in the same cycle.
- A start accepted at edge N gives busy=1 and counters=0 after edge N; the first countable item is at edge N+1.
- rst=0 overrides any simultaneous command. Reset mid-run returns to IDLE with all outputs at reset values after that edge.
- Back-to-back items (item high every cycle) are counted every cycle with no lost strobes.

## Configuration
- AUTO_RESTART_EN defined:
  - On the final box close, the block stays in RUN. Both counters clear to 0, and the latched target is kept.
  - done is a one-cycle pulse, coincident with box_pulse.
  - The DONE state is unreachable.
- AUTO_RESTART_EN undefined: DONE behaviour as specified above; done is a level.

## Test plan
- Reset: rst=0 for 2 cycles with start/item active -> state=0, all counts 0, busy=0, done=0.
- Full run: target=2, start, then 24 consecutive item strobes:
  - item_cnt reaches 11, then 0.
  - box_pulse fires after items 12 and 24.
  - Final state: box_cnt=2, state=3, done=1, busy=0.
  - 5 further items leave the counts unchanged.
- Pause and stop:
  - Run, 5 items, pause=1 with 3 items during pause -> item_cnt stays 5.
  - pause=0, 2 items -> item_cnt=7.
  - stop -> state=0, counts 0.
- Invalid start: target=0 start -> stays IDLE. target=10 start (MAX_BOXES=9) -> stays IDLE. target=1 start -> RUN.
- Priority and mid-run reset:
  - stop and start in the same cycle while in RUN -> IDLE.
  - rst=0 coincident with the 12th item -> counts 0, no box_pulse.
- AUTO_RESTART_EN: target=1, 36 items -> three box_pulse/done pulses, state remains 1, item_cnt=0 and box_cnt=0 at the end.
